// File: rtl/sparse_stream_pkg.sv
// Shared definitions for the sparse unit-test stream harness: word format,
// special tokens, sink FSM states and the stall LFSR step.
package sparse_stream_pkg;

  localparam int STREAM_W = 17;
  localparam logic [STREAM_W-1:0] DONE_TOKEN      = 17'h10100;
  localparam logic [STREAM_W-1:0] STOP_TOKEN_BASE = 17'h10000;
  localparam int ARM_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    ARM   = 3'd2,
    RECV  = 3'd3,
    DONE  = 3'd4
  } sink_state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/glb_sink_mem.sv
// Capture memory for the stream sink: one write port, one registered read
// port; a same-address read and write in one cycle returns the old word.
module glb_sink_mem #(
  parameter int DEPTH = 2048,
  parameter int W     = 17
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-1:0]             o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/glb_read_sink.sv
// Receiving end of the 17-bit GLB valid/ready stream: captures words into local
// memory, backpressures with LFSR-driven stalls and flags end of stream.
module glb_read_sink
  import sparse_stream_pkg::*;
#(
  parameter int          DEPTH     = 2048,
  parameter int          TX_SIZE   = 2048,
  parameter bit          STALL_EN  = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [STREAM_W-1:0]      data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   num_rx,
  output logic                     overflow,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [STREAM_W-1:0]      rd_data,
  output sink_state_t              o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a word moves on a rising clk edge where valid & ready are both
  // high. ready is registered and only ever high in RECV; the source must hold
  // data stable while valid is high and ready is low.

  sink_state_t   r_state, w_state_next;
  logic [1:0]    r_wait_cnt;
  logic [15:0]   r_lfsr;
  logic          r_ready, w_ready_next;
  logic          r_done;
  logic          r_overflow;
  logic [CW-1:0] r_num_rx;

  logic w_xfer, w_full, w_store, w_end, w_clear, w_stall;

  assign w_xfer  = valid & r_ready;
  assign w_full  = (r_num_rx == CW'(DEPTH));
  assign w_store = w_xfer & ~w_full;
  assign w_end   = w_xfer & ((data == DONE_TOKEN) ||
                   ((TX_SIZE != 0) && w_store && (int'(r_num_rx) + 1 == TX_SIZE)));
  assign w_clear = flush | (r_state == FLUSH);
  assign w_stall = STALL_EN & (r_lfsr[3:0] < 4'd4);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    w_state_next = IDLE;
      FLUSH:   if (!flush) w_state_next = ARM;
      ARM:     if (r_wait_cnt == 2'(ARM_CYCLES - 1)) w_state_next = RECV;
      RECV:    if (w_end) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = FLUSH;
  end

  // ready for the coming cycle is judged on the LFSR value of this cycle
  assign w_ready_next = (w_state_next == RECV) & ~w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_num_rx   <= '0;
      r_wait_cnt <= '0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
      if (w_clear) begin
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
        r_num_rx   <= '0;
        r_wait_cnt <= '0;
        r_lfsr     <= LFSR_SEED;
      end else begin
        if (r_state == ARM)  r_wait_cnt <= r_wait_cnt + 2'd1;
        if (r_state == RECV) r_lfsr     <= lfsr_step(r_lfsr);
        if (w_store)         r_num_rx   <= r_num_rx + CW'(1);
        if (w_xfer & w_full) r_overflow <= 1'b1;
        if (w_end)           r_done     <= 1'b1;
      end
    end
  end

  glb_sink_mem #(
    .DEPTH (DEPTH),
    .W     (STREAM_W)
  ) u_mem (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (w_store),
    .i_wr_addr (r_num_rx[AW-1:0]),
    .i_wr_data (data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign ready    = r_ready;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign num_rx   = r_num_rx;
  assign o_state  = r_state;

endmodule

// File: tb/tb_glb_read_sink.sv
// Bench for glb_read_sink: three configurations share one stimulus bus, and the
// selected one is checked against a queue-based capture model and an LFSR stall model.
module tb_glb_read_sink;
  import sparse_stream_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, flush, valid;
  logic [16:0] data;
  logic [10:0] rd_addr;

  logic        rdy0, rdy1, rdy2, dn0, dn1, dn2, ov0, ov1, ov2;
  logic [4:0]  nrx0;
  logic [8:0]  nrx1;
  logic [3:0]  nrx2;
  logic [16:0] rdd0, rdd1, rdd2;
  sink_state_t st0, st1, st2;

  logic [2:0]  rdy, dn, ov;
  logic [11:0] nrx [3];
  logic [16:0] rdd [3];
  sink_state_t st  [3];

  int sel;
  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] q_in[$];
  logic [16:0] exp_q[$];
  logic        exp_ovf, exp_done;

  always #5 clk = ~clk;

  glb_read_sink #(.DEPTH(16), .TX_SIZE(4), .STALL_EN(1'b0), .LFSR_SEED(SEED)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .data(data), .valid(valid),
    .ready(rdy0), .done(dn0), .num_rx(nrx0), .overflow(ov0),
    .rd_addr(rd_addr[3:0]), .rd_data(rdd0), .o_state(st0));

  glb_read_sink #(.DEPTH(256), .TX_SIZE(0), .STALL_EN(1'b1), .LFSR_SEED(SEED)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .data(data), .valid(valid),
    .ready(rdy1), .done(dn1), .num_rx(nrx1), .overflow(ov1),
    .rd_addr(rd_addr[7:0]), .rd_data(rdd1), .o_state(st1));

  glb_read_sink #(.DEPTH(8), .TX_SIZE(0), .STALL_EN(1'b1), .LFSR_SEED(SEED)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .data(data), .valid(valid),
    .ready(rdy2), .done(dn2), .num_rx(nrx2), .overflow(ov2),
    .rd_addr(rd_addr[2:0]), .rd_data(rdd2), .o_state(st2));

  assign rdy = {rdy2, rdy1, rdy0};
  assign dn  = {dn2, dn1, dn0};
  assign ov  = {ov2, ov1, ov0};
  assign nrx[0] = 12'(nrx0);
  assign nrx[1] = 12'(nrx1);
  assign nrx[2] = 12'(nrx2);
  assign rdd[0] = rdd0;
  assign rdd[1] = rdd1;
  assign rdd[2] = rdd2;
  assign st[0]  = st0;
  assign st[1]  = st1;
  assign st[2]  = st2;

  // ---------------- clock / reset helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11: feedback is the parity of the tapped bits
  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  // ---------------- driver tasks ----------------
  // Flush pulse, then three ARM cycles with ready low; returns on the first RECV cycle.
  task automatic arm();
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_done = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("flush_num_rx", 32'(nrx[sel]), 32'd0);
    chk("flush_done", 32'(dn[sel]), 32'd0);
    chk("flush_overflow", 32'(ov[sel]), 32'd0);
    chk("arm_ready0", 32'(rdy[sel]), 32'd0);
    step();
    chk("arm_ready1", 32'(rdy[sel]), 32'd0);
    step();
    chk("arm_ready2", 32'(rdy[sel]), 32'd0);
    step();
  endtask

  // Offers q_in with valid held high, predicting ready from the stall LFSR model.
  task automatic recv_stream(input bit stall_en, input int depth, input int tx_size);
    logic [15:0] prev = SEED;
    logic [15:0] cur  = SEED;
    logic        exp_r;
    int i = 0;
    int cyc = 0;
    int budget = 20 * q_in.size() + 50;
    while (i < q_in.size() && cyc < budget) begin
      exp_r = !(stall_en && (prev[3:0] < 4'd4));
      chk("ready_model", 32'(rdy[sel]), 32'(exp_r));
      valid = 1'b1;
      data  = q_in[i];
      if (rdy[sel]) begin
        if (exp_q.size() < depth) exp_q.push_back(q_in[i]);
        else exp_ovf = 1'b1;
        if (q_in[i] == DONE_TOKEN || (tx_size != 0 && exp_q.size() == tx_size))
          exp_done = 1'b1;
        i++;
      end
      prev = cur;
      cur  = lfsr_model(cur);
      step();
      cyc++;
    end
    valid = 1'b0;
    data  = '0;
    chk("stream_words_accepted", 32'(i), 32'(q_in.size()));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_capture(input string tag);
    chk({tag, "_num_rx"}, 32'(nrx[sel]), 32'(exp_q.size()));
    chk({tag, "_done"}, 32'(dn[sel]), 32'(exp_done));
    chk({tag, "_overflow"}, 32'(ov[sel]), 32'(exp_ovf));
    for (int a = 0; a < exp_q.size(); a++) begin
      rd_addr = 11'(a);
      step();
      chk({tag, "_mem"}, 32'(rdd[sel]), 32'(exp_q[a]));
    end
  endtask

  function automatic logic [16:0] rand_word();
    if ($urandom_range(0, 7) == 0)
      return STOP_TOKEN_BASE + 17'($urandom_range(0, 255));
    return {1'b0, 16'($urandom_range(0, 65535))};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; data = '0; rd_addr = '0; sel = 0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      chk("rst_done", 32'(dn[k]), 32'd0);
      chk("rst_num_rx", 32'(nrx[k]), 32'd0);
      chk("rst_overflow", 32'(ov[k]), 32'd0);
      chk("rst_rd_data", 32'(rdd[k]), 32'd0);
      chk("rst_state", 32'(st[k]), 32'(IDLE));
    end
    rst = 1'b0;
    step();

    // TX_SIZE=4, no stalls: fixed words 1..4, then a random 4-word run
    sel = 0;
    arm();
    q_in = '{17'h00001, 17'h00002, 17'h00003, 17'h00004};
    recv_stream(1'b0, 16, 4);
    chk("tx4_ready_after", 32'(rdy[sel]), 32'd0);
    chk("tx4_state", 32'(st[sel]), 32'(DONE));
    check_capture("tx4");
    arm();
    q_in.delete();
    for (int k = 0; k < 4; k++) q_in.push_back({1'b0, 16'($urandom_range(0, 65535))});
    recv_stream(1'b0, 16, 4);
    check_capture("tx4_rand");

    // Stop token is captured but only the DONE token ends the stream
    sel = 1;
    arm();
    q_in = '{17'h00005, 17'h10000, 17'h00007, 17'h10100};
    recv_stream(1'b1, 256, 0);
    check_capture("token");

    // 200 words under LFSR stalls, DONE token last
    arm();
    q_in.delete();
    for (int k = 0; k < 199; k++) q_in.push_back(rand_word());
    q_in.push_back(DONE_TOKEN);
    recv_stream(1'b1, 256, 0);
    check_capture("stall200");

    // DEPTH=8: 10 data words then DONE overflows the memory
    sel = 2;
    arm();
    q_in.delete();
    for (int k = 0; k < 10; k++) q_in.push_back({1'b0, 16'($urandom_range(0, 65535))});
    q_in.push_back(DONE_TOKEN);
    recv_stream(1'b1, 8, 0);
    check_capture("ovf");

    // Mid-stream flush after 3 of 6 words; restarted stream lands at address 0
    sel = 1;
    arm();
    q_in.delete();
    for (int k = 0; k < 3; k++) q_in.push_back(rand_word());
    recv_stream(1'b1, 256, 0);
    chk("mid_num_rx_before", 32'(nrx[sel]), 32'd3);
    arm();
    q_in.delete();
    for (int k = 0; k < 5; k++) q_in.push_back(rand_word());
    q_in.push_back(DONE_TOKEN);
    recv_stream(1'b1, 256, 0);
    check_capture("restart");

    // rst together with flush while receiving: reset wins
    arm();
    q_in.delete();
    for (int k = 0; k < 2; k++) q_in.push_back(rand_word());
    recv_stream(1'b1, 256, 0);
    rst = 1'b1;
    flush = 1'b1;
    step();
    chk("rstflush_state", 32'(st[sel]), 32'(IDLE));
    chk("rstflush_ready", 32'(rdy[sel]), 32'd0);
    chk("rstflush_num_rx", 32'(nrx[sel]), 32'd0);
    rst = 1'b0;
    flush = 1'b0;
    step();
    chk("rstflush_idle_hold", 32'(st[sel]), 32'(IDLE));
    arm();
    q_in = '{17'h00011, 17'h00022, DONE_TOKEN};
    recv_stream(1'b1, 256, 0);
    check_capture("rearm");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
